// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package sram_controller_pkg;

  typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, DONE} state_t;

  localparam int MEM_BASE_DEFAULT = 1024;
  localparam int SRAM_W           = 16;

endpackage

// File: rtl/sram_controller.sv
// Serves one 32-bit MEM-stage read/write as two 16-bit SRAM accesses plus a settle wait.
// Latency 3+WAIT_CYCLES cycles from request to the one-cycle ready pulse; ready is low while busy.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int MEM_BASE    = MEM_BASE_DEFAULT,
  parameter int WAIT_CYCLES = 3,
  parameter int ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       address,
  input  logic [31:0]       writeData,
  output logic [31:0]       readData,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we_n,
  output logic [SRAM_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [SRAM_W-1:0] sram_dq_in
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              op_wr;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       data_q;

  logic [31:0]       off;
  logic [ADDR_W-1:0] req_base;
  logic              req_wr;

  // Byte offset into SRAM space; the low two bits select a byte and are dropped.
  assign off      = address - 32'(MEM_BASE);
  assign req_base = {off[ADDR_W:2], 1'b0};
  // A simultaneous read and write request is served as a read only.
  assign req_wr   = wr_en && !rd_en;

  assign ready = (state == IDLE && !rd_en && !wr_en) || state == DONE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      op_wr       <= 1'b0;
      base_q      <= '0;
      data_q      <= '0;
      readData    <= '0;
      sram_addr   <= '0;
      sram_we_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
      sram_dq_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          sram_addr <= '0;
          if (rd_en || wr_en) begin
            op_wr     <= req_wr;
            base_q    <= req_base;
            data_q    <= writeData;
            sram_addr <= req_base;
            state     <= LOW;
            if (req_wr) begin
              sram_we_n   <= 1'b0;
              sram_dq_oe  <= 1'b1;
              sram_dq_out <= writeData[15:0];
            end
          end
        end
        LOW: begin
          if (!op_wr) readData[15:0] <= sram_dq_in;
          sram_addr <= base_q | ADDR_W'(1);
          state     <= HIGH;
          if (op_wr) begin
            sram_we_n   <= 1'b0;
            sram_dq_oe  <= 1'b1;
            sram_dq_out <= data_q[31:16];
          end
        end
        HIGH: begin
          if (!op_wr) readData[31:16] <= sram_dq_in;
          sram_addr  <= base_q;
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          state      <= (WAIT_CYCLES == 0) ? DONE : WAIT;
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DONE: begin
          // Any request seen here belongs to the next instruction; taken next IDLE.
          sram_addr <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
